// File: rtl/mcu_spi_pkg.sv
// ============================================================================
// mcu_spi_pkg : shared constants and types for the MCU SPI slave
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mcu_spi_pkg;
    localparam logic       MCU_SPI_IDLE_MISO   = 1'b1;
    localparam logic [7:0] MCU_SPI_FRAME_REPLY = 8'h00;
    localparam int         MCU_SPI_BITS        = 8;
    localparam int         MCU_SPI_CNT_W       = $clog2(MCU_SPI_BITS);

    typedef logic [MCU_SPI_CNT_W-1:0] bit_cnt_t;
endpackage

`default_nettype wire

// File: rtl/mcu_spi_sync.sv
// ============================================================================
// spi_sync : multi-stage single-bit synchroniser with async active-low reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

`default_nettype wire

// File: rtl/mcu_spi.sv
// ============================================================================
// mcu_spi  : SPI mode-0 slave, MSB first, byte strobes upstream, reply on MISO
//            Optional frame-abort timeout enabled by MCU_SPI_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcu_spi #(
    parameter int SYNC_STAGES    = 2
`ifdef MCU_SPI_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_csn,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       byte_strobe,
    output logic       byte_start,
    output logic [7:0] byte_data,
    input  logic [7:0] reply_data,
    output logic       frame_active,
    output logic       timeout_err
);
    import mcu_spi_pkg::*;

    logic csn_s, sck_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
        .clk(clk), .reset_n(reset_n), .d_i(spi_csn), .q_o(csn_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset_n(reset_n), .d_i(spi_sck), .q_o(sck_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d_i(spi_mosi), .q_o(mosi_s));

    logic       csn_d1_q, csn_d2_q, sck_d1_q, sck_d2_q, mosi_d1_q;
    logic [6:0] rx_sr_q, rx_sr_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] byte_data_q, byte_data_d;
    bit_cnt_t   bit_cnt_q, bit_cnt_d;
    logic       first_q, first_d;
    logic       load_pend_q, load_pend_d;
    logic       strobe_q, strobe_d;
    logic       start_q, start_d;
    logic       sck_rise, sck_fall, csn_rise, csn_fall, sck_en;

`ifdef MCU_SPI_TIMEOUT_EN
    logic [19:0] idle_q, idle_d;
    logic        err_q, err_d;
`endif

    // One extra delay stage after the synchroniser so edges compare two clean samples
    assign sck_rise = sck_d1_q & ~sck_d2_q;
    assign sck_fall = ~sck_d1_q & sck_d2_q;
    assign csn_fall = ~csn_d1_q & csn_d2_q;
    assign csn_rise = csn_d1_q & ~csn_d2_q;
    // The sample in which CSN rises still accepts an SCK edge, so a final bit is not lost
    assign sck_en   = ~csn_d1_q | ~csn_d2_q;

    always_comb begin
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        byte_data_d = byte_data_q;
        bit_cnt_d   = bit_cnt_q;
        first_d     = first_q;
        load_pend_d = load_pend_q;
        strobe_d    = 1'b0;
        start_d     = 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
        idle_d      = idle_q;
        err_d       = 1'b0;
`endif

        if (load_pend_q) begin
            tx_sr_d     = reply_data;
            load_pend_d = 1'b0;
        end

        if (sck_en && sck_rise) begin
            rx_sr_d   = {rx_sr_q[5:0], mosi_d1_q};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == bit_cnt_t'(MCU_SPI_BITS - 1)) begin
                byte_data_d = {rx_sr_q, mosi_d1_q};
                strobe_d    = 1'b1;
                start_d     = first_q;
                first_d     = 1'b0;
                load_pend_d = 1'b1;
            end
        end

        if (sck_en && sck_fall && (bit_cnt_q != '0)) begin
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end

        if (csn_fall) begin
            tx_sr_d = MCU_SPI_FRAME_REPLY;
        end

        if (csn_d1_q) begin
            bit_cnt_d = '0;
            first_d   = 1'b1;
        end

`ifdef MCU_SPI_TIMEOUT_EN
        if (sck_rise || sck_fall || csn_rise || csn_fall || csn_d1_q) begin
            idle_d = '0;
        end else if (idle_q == 20'(TIMEOUT_CYCLES - 1)) begin
            idle_d      = '0;
            bit_cnt_d   = '0;
            first_d     = 1'b1;
            load_pend_d = 1'b0;
            tx_sr_d     = MCU_SPI_FRAME_REPLY;
            err_d       = 1'b1;
        end else begin
            idle_d = idle_q + 20'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csn_d1_q    <= 1'b1;
            csn_d2_q    <= 1'b1;
            sck_d1_q    <= 1'b0;
            sck_d2_q    <= 1'b0;
            mosi_d1_q   <= 1'b0;
            rx_sr_q     <= '0;
            tx_sr_q     <= MCU_SPI_FRAME_REPLY;
            byte_data_q <= 8'h00;
            bit_cnt_q   <= '0;
            first_q     <= 1'b1;
            load_pend_q <= 1'b0;
            strobe_q    <= 1'b0;
            start_q     <= 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
            idle_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            csn_d1_q    <= csn_s;
            csn_d2_q    <= csn_d1_q;
            sck_d1_q    <= sck_s;
            sck_d2_q    <= sck_d1_q;
            mosi_d1_q   <= mosi_s;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            byte_data_q <= byte_data_d;
            bit_cnt_q   <= bit_cnt_d;
            first_q     <= first_d;
            load_pend_q <= load_pend_d;
            strobe_q    <= strobe_d;
            start_q     <= start_d;
`ifdef MCU_SPI_TIMEOUT_EN
            idle_q      <= idle_d;
            err_q       <= err_d;
`endif
        end
    end

    assign spi_miso     = csn_d1_q ? MCU_SPI_IDLE_MISO : tx_sr_q[7];
    assign byte_strobe  = strobe_q;
    assign byte_start   = start_q;
    assign byte_data    = byte_data_q;
    assign frame_active = ~csn_d1_q;
`ifdef MCU_SPI_TIMEOUT_EN
    assign timeout_err  = err_q;
`else
    assign timeout_err  = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_mcu_spi.sv
// ============================================================================
// tb_mcu_spi : directed self-checking bench for mcu_spi
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_mcu_spi;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic [7:0] reply_data = 8'h00;
    logic       spi_miso, byte_strobe, byte_start, frame_active, timeout_err;
    logic [7:0] byte_data;

    mcu_spi #(
        .SYNC_STAGES(2)
`ifdef MCU_SPI_TIMEOUT_EN
       ,.TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .spi_csn(spi_csn), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .byte_strobe(byte_strobe),
        .byte_start(byte_start), .byte_data(byte_data), .reply_data(reply_data),
        .frame_active(frame_active), .timeout_err(timeout_err));

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         n_str = 0;
    int         n_err = 0;
    int         n_bad_start = 0;
    logic [7:0] got_d [64];
    logic       got_s [64];
    logic [7:0] rtab  [3] = '{8'h04, 8'h5C, 8'h42};

    // Strobe logger and reply model: reply presented while the strobe is high
    always @(negedge clk) begin
        if (byte_strobe) begin
            if (n_str < 64) begin
                got_d[n_str] = byte_data;
                got_s[n_str] = byte_start;
            end
            reply_data = rtab[n_str % 3];
            n_str      = n_str + 1;
        end else if (byte_start) begin
            n_bad_start = n_bad_start + 1;
        end
        if (timeout_err) n_err = n_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sck_bits(input logic [7:0] v, input int nb, input int half,
                            output logic [7:0] mb);
        mb = 8'h00;
        for (int i = 0; i < nb; i++) begin
            spi_mosi = v[7-i];
            repeat (half) @(negedge clk);
            spi_sck = 1'b1;
            mb = {mb[6:0], spi_miso};
            repeat (half) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic open_frame();
        spi_csn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic close_frame();
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    logic [7:0] mb, m0, m1, m2;
    int         base;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_strobe", {31'd0, byte_strobe}, 0);
        chk("rst_start", {31'd0, byte_start}, 0);
        chk("rst_data", {24'd0, byte_data}, 0);
        chk("rst_miso", {31'd0, spi_miso}, 1);
        chk("rst_active", {31'd0, frame_active}, 0);
        chk("rst_terr", {31'd0, timeout_err}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // single byte frame
        open_frame();
        chk("t1_active", {31'd0, frame_active}, 1);
        sck_bits(8'hA5, 8, 8, mb);
        close_frame();
        chk("t1_count", n_str, 1);
        chk("t1_data", {24'd0, got_d[0]}, 32'hA5);
        chk("t1_start", {31'd0, got_s[0]}, 1);
        chk("t1_miso", {24'd0, mb}, 0);
        chk("t1_inactive", {31'd0, frame_active}, 0);
        chk("t1_miso_idle", {31'd0, spi_miso}, 1);

        // three-byte frame with replies
        base = n_str;
        open_frame();
        sck_bits(8'h00, 8, 8, m0);
        sck_bits(8'h00, 8, 8, m1);
        sck_bits(8'h00, 8, 8, m2);
        close_frame();
        chk("t2_count", n_str - base, 3);
        chk("t2_start0", {31'd0, got_s[base]}, 1);
        chk("t2_start1", {31'd0, got_s[base+1]}, 0);
        chk("t2_start2", {31'd0, got_s[base+2]}, 0);
        chk("t2_miso0", {24'd0, m0}, 32'h00);
        chk("t2_miso1", {24'd0, m1}, 32'h5C);
        chk("t2_miso2", {24'd0, m2}, 32'h42);

        // aborted partial byte then fresh frame
        base = n_str;
        open_frame();
        sck_bits(8'hFF, 5, 8, mb);
        close_frame();
        chk("t3_partial", n_str - base, 0);
        open_frame();
        sck_bits(8'h3C, 8, 8, mb);
        close_frame();
        chk("t3_count", n_str - base, 1);
        chk("t3_data", {24'd0, got_d[base]}, 32'h3C);
        chk("t3_start", {31'd0, got_s[base]}, 1);

        // fast SCK (clk/4), short CSN-high gap between frames
        base = n_str;
        spi_csn = 1'b0;
        sck_bits(8'h96, 8, 2, mb);
        repeat (2) @(negedge clk);
        spi_csn = 1'b1;
        repeat (8) @(negedge clk);
        spi_csn = 1'b0;
        sck_bits(8'h69, 8, 2, mb);
        close_frame();
        chk("t4_count", n_str - base, 2);
        chk("t4_data0", {24'd0, got_d[base]}, 32'h96);
        chk("t4_start0", {31'd0, got_s[base]}, 1);
        chk("t4_data1", {24'd0, got_d[base+1]}, 32'h69);
        chk("t4_start1", {31'd0, got_s[base+1]}, 1);

        // reset in the middle of a byte
        base = n_str;
        open_frame();
        sck_bits(8'hF0, 4, 8, mb);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_strobe", {31'd0, byte_strobe}, 0);
        chk("t5_data", {24'd0, byte_data}, 0);
        chk("t5_miso", {31'd0, spi_miso}, 1);
        chk("t5_active", {31'd0, frame_active}, 0);
        spi_csn = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        open_frame();
        sck_bits(8'h81, 8, 8, mb);
        close_frame();
        chk("t5_count", n_str - base, 1);
        chk("t5_data81", {24'd0, got_d[base]}, 32'h81);
        chk("t5_start", {31'd0, got_s[base]}, 1);

`ifdef MCU_SPI_TIMEOUT_EN
        // stalled frame aborted by the idle timeout
        base = n_str;
        open_frame();
        sck_bits(8'hE0, 3, 8, mb);
        repeat (150) @(negedge clk);
        chk("t6_terr", n_err, 1);
        sck_bits(8'h7E, 8, 8, mb);
        close_frame();
        chk("t6_count", n_str - base, 1);
        chk("t6_data", {24'd0, got_d[base]}, 32'h7E);
        chk("t6_start", {31'd0, got_s[base]}, 1);
        chk("terr_total", n_err, 1);
`else
        chk("terr_total", n_err, 0);
`endif
        chk("start_no_strobe", n_bad_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
